psum_axis_packer: RTL and testbench

- Downstream stage of the accelerator top: consumes the 1280-bit partial-sum vector (64 lanes x 20 bits) produced after each compute pass.
- Serializes the vector, one lane per beat, onto a 32-bit AXI4-Stream master for DMA write-back.
- Applies optional ReLU and sign-extension per lane.
- Asserts TLAST at the end of a frame of a programmable number of vectors.

---
 rtl/psum_axis_packer.sv | 149 ++++++++++++++
 tb/tb_psum_axis_packer.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/psum_axis_packer.sv
// psum_axis_packer: serializes a LANES x PSUM_WIDTH partial-sum vector onto a
// 32-bit AXI4-Stream master, one lane per beat, with optional ReLU, sign
// extension and TLAST framing over a programmable number of vectors.
module psum_axis_packer #(
  parameter int LANES                = 64,
  parameter int PSUM_WIDTH           = 20,
  parameter int C_M_AXIS_TDATA_WIDTH = 32,
  parameter int FRAME_CNT_WIDTH      = 16
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic [LANES*PSUM_WIDTH-1:0]         psum_in,
  input  logic                                psum_valid,
  output logic                                psum_ready,
  input  logic [6:0]                          lane_count,
  input  logic                                relu_en,
  input  logic [FRAME_CNT_WIDTH-1:0]          frame_len,
  output logic [C_M_AXIS_TDATA_WIDTH-1:0]     M_AXIS_TDATA,
  output logic [C_M_AXIS_TDATA_WIDTH/8-1:0]   M_AXIS_TSTRB,
  output logic                                M_AXIS_TLAST,
  output logic                                M_AXIS_TVALID,
  input  logic                                M_AXIS_TREADY,
  output logic                                busy,
  output logic                                frame_done
);

  localparam int TW = C_M_AXIS_TDATA_WIDTH;
  localparam int VW = LANES * PSUM_WIDTH;
  localparam int FW = FRAME_CNT_WIDTH;

  typedef enum logic {IDLE, SEND} state_t;

  state_t          state_q;
  logic [VW-1:0]   psum_q;
  logic [6:0]      lcnt_q;     // effective lane count of the captured vector
  logic            relu_q;
  logic [FW-1:0]   flen_q;     // effective frame length of the captured vector
  logic [6:0]      lane_q;     // lane currently presented on the stream
  logic [FW-1:0]   vcnt_q;     // vectors completed within the current frame
  logic [TW-1:0]   tdata_q;
  logic            tlast_q;
  logic            tvalid_q;
  logic            ready_q;
  logic            busy_q;
  logic            done_q;

  logic [6:0]      eff_lc_in;
  logic [FW-1:0]   eff_fl_in;
  logic            xfer;
  logic            last_lane;
  logic            last_vec;
  logic            last_vec_in;
  logic [6:0]      nxt_lane;

  // Extract one lane, sign-extend to the stream width, optionally clamp to 0.
  function automatic logic [TW-1:0] lane_val(input logic [VW-1:0] v,
                                             input logic [6:0]    idx,
                                             input logic          relu);
    logic [PSUM_WIDTH-1:0] p;
    logic [TW-1:0]         r;
    p = v[int'(idx)*PSUM_WIDTH +: PSUM_WIDTH];
    r = {TW{p[PSUM_WIDTH-1]}};
    r[PSUM_WIDTH-1:0] = p;
    if (relu && p[PSUM_WIDTH-1]) r = '0;
    return r;
  endfunction

  // Effective configuration and beat/vector boundary decode.
  always_comb begin
    eff_lc_in   = (lane_count == 7'd0 || lane_count > 7'(LANES)) ? 7'(LANES) : lane_count;
    eff_fl_in   = (frame_len == '0) ? FW'(1) : frame_len;
    xfer        = tvalid_q & M_AXIS_TREADY;
    nxt_lane    = lane_q + 7'd1;
    last_lane   = (lane_q == lcnt_q - 7'd1);
    // >= keeps the frame bounded if frame_len shrank between vectors
    last_vec    = (vcnt_q >= flen_q - FW'(1));
    last_vec_in = (vcnt_q >= eff_fl_in - FW'(1));
  end

  // Capture/serialize FSM; all stream outputs are registered.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      psum_q   <= '0;
      lcnt_q   <= '0;
      relu_q   <= 1'b0;
      flen_q   <= '0;
      lane_q   <= '0;
      vcnt_q   <= '0;
      tdata_q  <= '0;
      tlast_q  <= 1'b0;
      tvalid_q <= 1'b0;
      ready_q  <= 1'b1;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (psum_valid) begin
            state_q  <= SEND;
            psum_q   <= psum_in;
            lcnt_q   <= eff_lc_in;
            relu_q   <= relu_en;
            flen_q   <= eff_fl_in;
            lane_q   <= '0;
            tdata_q  <= lane_val(psum_in, 7'd0, relu_en);
            tlast_q  <= (eff_lc_in == 7'd1) && last_vec_in;
            tvalid_q <= 1'b1;
            ready_q  <= 1'b0;
            busy_q   <= 1'b1;
          end
        end
        SEND: begin
          if (xfer) begin
            if (last_lane) begin
              state_q  <= IDLE;
              tvalid_q <= 1'b0;
              tlast_q  <= 1'b0;
              ready_q  <= 1'b1;
              busy_q   <= 1'b0;
              lane_q   <= '0;
              if (last_vec) begin
                vcnt_q <= '0;
                done_q <= 1'b1;
              end else begin
                vcnt_q <= vcnt_q + FW'(1);
              end
            end else begin
              lane_q  <= nxt_lane;
              tdata_q <= lane_val(psum_q, nxt_lane, relu_q);
              tlast_q <= (nxt_lane == lcnt_q - 7'd1) && last_vec;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign M_AXIS_TDATA  = tdata_q;
  assign M_AXIS_TSTRB  = '1;
  assign M_AXIS_TLAST  = tlast_q;
  assign M_AXIS_TVALID = tvalid_q;
  assign psum_ready    = ready_q;
  assign busy          = busy_q;
  assign frame_done    = done_q;

endmodule

// File: tb/tb_psum_axis_packer.sv
// Self-checking bench for psum_axis_packer: constant-vector table, hand-written
// corner sequences and a randomized phase against a queue-based stream model.
module tb_psum_axis_packer;

  localparam int L  = 64;
  localparam int PW = 20;
  localparam int TW = 32;
  localparam int FW = 16;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [L*PW-1:0]   psum_in = '0;
  logic              psum_valid = 1'b0;
  logic              psum_ready;
  logic [6:0]        lane_count = 7'd1;
  logic              relu_en = 1'b0;
  logic [FW-1:0]     frame_len = 16'd1;
  logic [TW-1:0]     M_AXIS_TDATA;
  logic [TW/8-1:0]   M_AXIS_TSTRB;
  logic              M_AXIS_TLAST;
  logic              M_AXIS_TVALID;
  logic              M_AXIS_TREADY = 1'b1;
  logic              busy;
  logic              frame_done;

  psum_axis_packer #(.LANES(L), .PSUM_WIDTH(PW), .C_M_AXIS_TDATA_WIDTH(TW),
                     .FRAME_CNT_WIDTH(FW)) dut (
    .clk(clk), .rst(rst), .psum_in(psum_in), .psum_valid(psum_valid),
    .psum_ready(psum_ready), .lane_count(lane_count), .relu_en(relu_en),
    .frame_len(frame_len), .M_AXIS_TDATA(M_AXIS_TDATA), .M_AXIS_TSTRB(M_AXIS_TSTRB),
    .M_AXIS_TLAST(M_AXIS_TLAST), .M_AXIS_TVALID(M_AXIS_TVALID),
    .M_AXIS_TREADY(M_AXIS_TREADY), .busy(busy), .frame_done(frame_done));

  always #5 clk = ~clk;

  typedef struct packed { logic [31:0] d; logic l; } beat_t;

  int     checks = 0;
  int     failures = 0;
  beat_t  exp_q[$];
  beat_t  obs_q[$];
  int     count_m = 0;
  int     cap_cnt = 0;
  int     fd_cnt = 0;
  logic   fd_exp = 1'b0;
  logic   stall_p = 1'b0;
  logic [31:0] stall_d = '0;
  logic   stall_l = 1'b0;
  logic   rnd_ready = 1'b0;
  logic   pat[$];

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (t=%0t)", n, act, exp, $time);
    end
  endtask

  // Reference lane value: signed integer of the lane, ReLU clamps below zero.
  function automatic logic [31:0] model_lane(input logic [L*PW-1:0] v, input int i,
                                             input logic relu);
    logic [PW-1:0] p;
    int s;
    p = v[i*PW +: PW];
    s = int'($signed(p));
    if (relu && s < 0) s = 0;
    return 32'(s);
  endfunction

  // Downstream ready: explicit pattern first, otherwise random or always-ready.
  always @(posedge clk) begin
    #1;
    if (pat.size() > 0) M_AXIS_TREADY = pat.pop_front();
    else if (rnd_ready) M_AXIS_TREADY = 1'($urandom_range(0, 1));
    else M_AXIS_TREADY = 1'b1;
  end

  // Monitor + model: inputs/outputs are stable at negedge and describe the
  // handshakes that the following posedge will perform.
  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      count_m = 0;
      fd_exp  = 1'b0;
      stall_p = 1'b0;
    end else begin
      chk("frame_done", 32'(frame_done), 32'(fd_exp));
      if (frame_done) fd_cnt++;
      fd_exp = 1'b0;
      chk("psum_ready", 32'(psum_ready), 32'(exp_q.size() == 0));
      chk("busy", 32'(busy), 32'(exp_q.size() != 0));
      chk("tvalid", 32'(M_AXIS_TVALID), 32'(exp_q.size() != 0));
      chk("tstrb", 32'(M_AXIS_TSTRB), 32'hF);
      if (stall_p) begin
        chk("stall_tvalid", 32'(M_AXIS_TVALID), 32'd1);
        chk("stall_tdata", M_AXIS_TDATA, stall_d);
        chk("stall_tlast", 32'(M_AXIS_TLAST), 32'(stall_l));
      end
      if (M_AXIS_TVALID && M_AXIS_TREADY) begin
        beat_t o;
        o.d = M_AXIS_TDATA;
        o.l = M_AXIS_TLAST;
        obs_q.push_back(o);
        if (exp_q.size() == 0) begin
          chk("unexpected_beat", 32'd1, 32'd0);
        end else begin
          beat_t e;
          e = exp_q.pop_front();
          chk("beat_data", M_AXIS_TDATA, e.d);
          chk("beat_last", 32'(M_AXIS_TLAST), 32'(e.l));
          fd_exp = e.l;
        end
      end
      stall_p = M_AXIS_TVALID && !M_AXIS_TREADY;
      stall_d = M_AXIS_TDATA;
      stall_l = M_AXIS_TLAST;
      if (psum_valid && psum_ready) begin
        int lc, fl;
        cap_cnt++;
        lc = (lane_count == 0 || int'(lane_count) > L) ? L : int'(lane_count);
        fl = (frame_len == 0) ? 1 : int'(frame_len);
        for (int i = 0; i < lc; i++) begin
          beat_t b;
          b.d = model_lane(psum_in, i, relu_en);
          b.l = (i == lc - 1) && (count_m == fl - 1);
          exp_q.push_back(b);
        end
        count_m = (count_m == fl - 1) ? 0 : count_m + 1;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [L*PW-1:0] rnd_vec();
    logic [L*PW-1:0] v;
    for (int j = 0; j < L*PW/32; j++) v[j*32 +: 32] = $urandom;
    return v;
  endfunction

  // Present a vector and hold psum_valid until it is accepted (bounded).
  task automatic send_vec(input logic [L*PW-1:0] v, input logic [6:0] lc,
                          input logic [FW-1:0] fl, input logic relu);
    int c0, n;
    psum_in = v; lane_count = lc; frame_len = fl; relu_en = relu;
    psum_valid = 1'b1;
    c0 = cap_cnt;
    n = 0;
    while (cap_cnt == c0 && n < 500) begin tick(); n++; end
    if (cap_cnt == c0) chk("capture_timeout", 32'd1, 32'd0);
    psum_valid = 1'b0;
    psum_in = rnd_vec();
    lane_count = 7'($urandom_range(0, 127));
    relu_en = ~relu;
    frame_len = 16'($urandom_range(0, 9));
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || !psum_ready) && n < 3000) begin tick(); n++; end
    if (n >= 3000) chk("idle_timeout", 32'd1, 32'd0);
    tick(); tick();
  endtask

  typedef struct {
    logic [6:0]    lc;
    logic          relu;
    logic [PW-1:0] in [4];
    logic [31:0]   ex [4];
    int            n;
  } vec_t;

  vec_t tbl[6];

  initial begin
    logic [L*PW-1:0] v;
    int c0, f0, nl;

    tbl[0] = '{7'd3, 1'b0, '{20'h00005, 20'hFFFFD, 20'h7FFFF, 20'h0},
               '{32'h00000005, 32'hFFFFFFFD, 32'h0007FFFF, 32'h0}, 3};
    tbl[1] = '{7'd3, 1'b1, '{20'h00005, 20'hFFFFD, 20'h7FFFF, 20'h0},
               '{32'h00000005, 32'h00000000, 32'h0007FFFF, 32'h0}, 3};
    tbl[2] = '{7'd4, 1'b0, '{20'h80000, 20'h00001, 20'hFFFFF, 20'h12345},
               '{32'hFFF80000, 32'h00000001, 32'hFFFFFFFF, 32'h00012345}, 4};
    tbl[3] = '{7'd4, 1'b1, '{20'h80000, 20'h00001, 20'hFFFFF, 20'h12345},
               '{32'h00000000, 32'h00000001, 32'h00000000, 32'h00012345}, 4};
    tbl[4] = '{7'd1, 1'b0, '{20'hFFFFF, 20'h0, 20'h0, 20'h0},
               '{32'hFFFFFFFF, 32'h0, 32'h0, 32'h0}, 1};
    tbl[5] = '{7'd2, 1'b1, '{20'h7FFFF, 20'h80000, 20'h0, 20'h0},
               '{32'h0007FFFF, 32'h00000000, 32'h0, 32'h0}, 2};

    // Reset state
    tick(); tick();
    chk("rst_tvalid", 32'(M_AXIS_TVALID), 32'd0);
    chk("rst_tlast", 32'(M_AXIS_TLAST), 32'd0);
    chk("rst_tdata", M_AXIS_TDATA, 32'd0);
    chk("rst_tstrb", 32'(M_AXIS_TSTRB), 32'hF);
    chk("rst_ready", 32'(psum_ready), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(frame_done), 32'd0);
    rst = 1'b0;
    tick();

    // Table of single-vector frames with constant expectations
    for (int t = 0; t < 6; t++) begin
      obs_q.delete();
      v = rnd_vec();
      for (int i = 0; i < 4; i++) v[i*PW +: PW] = tbl[t].in[i];
      send_vec(v, tbl[t].lc, 16'd1, tbl[t].relu);
      wait_idle();
      chk($sformatf("tbl%0d_beats", t), 32'(obs_q.size()), 32'(tbl[t].n));
      for (int i = 0; i < tbl[t].n && i < obs_q.size(); i++) begin
        chk($sformatf("tbl%0d_data%0d", t, i), obs_q[i].d, tbl[t].ex[i]);
        chk($sformatf("tbl%0d_last%0d", t, i), 32'(obs_q[i].l), 32'(i == tbl[t].n - 1));
      end
    end

    // Backpressure: stall pattern on a 4-lane vector
    obs_q.delete();
    v = rnd_vec();
    v[0*PW +: PW] = 20'h0000B; v[1*PW +: PW] = 20'hFFFF0;
    v[2*PW +: PW] = 20'h00003; v[3*PW +: PW] = 20'h80001;
    send_vec(v, 7'd4, 16'd1, 1'b0);
    pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    wait_idle();
    chk("bp_beats", 32'(obs_q.size()), 32'd4);
    if (obs_q.size() == 4) begin
      chk("bp_d0", obs_q[0].d, 32'h0000000B);
      chk("bp_d1", obs_q[1].d, 32'hFFFFFFF0);
      chk("bp_d2", obs_q[2].d, 32'h00000003);
      chk("bp_d3", obs_q[3].d, 32'hFFF80001);
    end

    // Framing: three 2-lane vectors per frame, then a fourth opens a new frame
    obs_q.delete();
    f0 = fd_cnt;
    for (int k = 0; k < 3; k++) send_vec(rnd_vec(), 7'd2, 16'd3, 1'b0);
    wait_idle();
    chk("frm_beats", 32'(obs_q.size()), 32'd6);
    nl = 0;
    foreach (obs_q[i]) if (obs_q[i].l) nl++;
    chk("frm_nlast", 32'(nl), 32'd1);
    if (obs_q.size() == 6) chk("frm_last6", 32'(obs_q[5].l), 32'd1);
    chk("frm_done_cnt", 32'(fd_cnt - f0), 32'd1);
    send_vec(rnd_vec(), 7'd2, 16'd3, 1'b0);
    wait_idle();
    if (obs_q.size() == 8) chk("frm4_nolast", 32'({obs_q[6].l, obs_q[7].l}), 32'd0);
    else chk("frm4_beats", 32'(obs_q.size()), 32'd8);

    // Reset during beat 2 of 4, then a fresh frame of two vectors
    obs_q.delete();
    send_vec(rnd_vec(), 7'd4, 16'd2, 1'b0);
    nl = 0;
    while (obs_q.size() < 1 && nl < 100) begin tick(); nl++; end
    rst = 1'b1;
    #1;
    chk("mrst_tvalid", 32'(M_AXIS_TVALID), 32'd0);
    chk("mrst_ready", 32'(psum_ready), 32'd1);
    chk("mrst_busy", 32'(busy), 32'd0);
    chk("mrst_tlast", 32'(M_AXIS_TLAST), 32'd0);
    tick(); tick();
    rst = 1'b0;
    tick();
    obs_q.delete();
    send_vec(rnd_vec(), 7'd2, 16'd2, 1'b0);
    send_vec(rnd_vec(), 7'd2, 16'd2, 1'b0);
    wait_idle();
    if (obs_q.size() == 4)
      chk("mrst_lasts", 32'({obs_q[0].l, obs_q[1].l, obs_q[2].l, obs_q[3].l}), 32'b0001);
    else chk("mrst_beats", 32'(obs_q.size()), 32'd4);

    // Defaults: lane_count=0 and frame_len=0; second vector held valid while busy
    obs_q.delete();
    c0 = cap_cnt;
    send_vec(rnd_vec(), 7'd0, 16'd0, 1'b0);
    send_vec(rnd_vec(), 7'd0, 16'd0, 1'b1);
    wait_idle();
    chk("def_caps", 32'(cap_cnt - c0), 32'd2);
    chk("def_beats", 32'(obs_q.size()), 32'd128);
    if (obs_q.size() == 128) begin
      chk("def_last63", 32'(obs_q[63].l), 32'd1);
      chk("def_nolast62", 32'(obs_q[62].l), 32'd0);
      chk("def_last127", 32'(obs_q[127].l), 32'd1);
    end

    // Randomized vectors with random backpressure, checked by the model
    rnd_ready = 1'b1;
    for (int k = 0; k < 24; k++)
      send_vec(rnd_vec(), 7'($urandom_range(0, 9)), 16'd3, 1'($urandom_range(0, 1)));
    wait_idle();
    rnd_ready = 1'b0;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got timeout expected completion");
    $fatal(1, "timeout");
  end

endmodule
